// File: rtl/summer_arbiter.sv
// Round-robin arbiter that lends one external clearable accumulator to NUM_REQ
// requesters for whole bursts and returns each burst sum tagged with its owner.
module summer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_SAMPLES = 2,
  parameter int DATA_SIZE   = 4,
  localparam int SUM_W      = $clog2(NUM_SAMPLES) + DATA_SIZE,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           acc_clr,
  output logic                           acc_valid,
  output logic [DATA_SIZE-1:0]           acc_data,
  input  logic [SUM_W-1:0]               acc_sum,
  output logic                           res_valid,
  output logic [SUM_W-1:0]               res_data,
  output logic [ID_W-1:0]                res_id,
  input  logic                           res_ready,
  output logic                           busy
);

  localparam int CNT_W = $clog2(NUM_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, OUT} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  grant, last_grant, pick, pick_idx;
  logic             found;
  logic             xfer;
  logic [CNT_W-1:0] count;

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    pick     = last_grant;
    pick_idx = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pick_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[pick_idx]) begin
        found = 1'b1;
        pick  = pick_idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_valid = 1'b0;
    acc_data  = '0;
    req_ready = '0;
    res_valid = 1'b0;
    xfer      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (found) state_nxt = CLEAR;
      end
      CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        req_ready[grant] = 1'b1;
        if (req_valid[grant]) begin
          xfer      = 1'b1;
          acc_valid = 1'b1;
          acc_data  = req_data[int'(grant)*DATA_SIZE +: DATA_SIZE];
          if (count == LAST_CNT) state_nxt = DRAIN;
        end
      end
      // Accumulator registers the last sample here, so its sum is final now.
      DRAIN: begin
        state_nxt = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      grant      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      res_data   <= '0;
      res_id     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:   if (found) grant <= pick;
        CLEAR:  count <= '0;
        STREAM: if (xfer) count <= count + CNT_W'(1);
        DRAIN: begin
          res_data <= acc_sum;
          res_id   <= grant;
        end
        OUT:    if (res_ready) last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_summer_arbiter.sv
// Directed bench for summer_arbiter with a clearable accumulator model attached.
module tb_summer_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int NUM_SAMPLES = 2;
  localparam int DATA_SIZE   = 4;
  localparam int SUM_W       = 5;
  localparam int ID_W        = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         acc_clr, acc_valid;
  logic [DATA_SIZE-1:0]         acc_data;
  logic [SUM_W-1:0]             acc_sum = '0;
  logic                         res_valid;
  logic [SUM_W-1:0]             res_data;
  logic [ID_W-1:0]              res_id;
  logic                         res_ready;
  logic                         busy;

  int checks = 0;
  int failures = 0;

  summer_arbiter #(.NUM_REQ(NUM_REQ), .NUM_SAMPLES(NUM_SAMPLES), .DATA_SIZE(DATA_SIZE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .acc_clr(acc_clr), .acc_valid(acc_valid), .acc_data(acc_data), .acc_sum(acc_sum),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Accumulator model: deliberately not reset, so a missing clear shows up.
  always @(posedge clk) begin
    if (acc_clr) acc_sum <= '0;
    else if (acc_valid) acc_sum <= acc_sum + SUM_W'(acc_data);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at posedge+1 after inputs are driven; checks at negedge, returns at next posedge+1.
  task automatic step(input string tag, input logic [31:0] clr, input logic [31:0] av,
                      input logic [31:0] ad, input logic [31:0] rdy, input logic [31:0] rv,
                      input logic [31:0] rd, input logic [31:0] rid, input logic [31:0] bz);
    #4;
    chk({tag, ".acc_clr"},   32'(acc_clr),   clr);
    chk({tag, ".acc_valid"}, 32'(acc_valid), av);
    chk({tag, ".acc_data"},  32'(acc_data),  ad);
    chk({tag, ".req_ready"}, 32'(req_ready), rdy);
    chk({tag, ".res_valid"}, 32'(res_valid), rv);
    chk({tag, ".busy"},      32'(busy),      bz);
    if (rv != 0) begin
      chk({tag, ".res_data"}, 32'(res_data), rd);
      chk({tag, ".res_id"},   32'(res_id),   rid);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.res_data", 32'(res_data), 0);
    chk("rst.res_id", 32'(res_id), 0);
    rst = 1'b1;

    // 1: req 0 sends 3 then 5
    req_valid = 4'b0001; req_data[3:0] = 4'd3;
    step("t1.idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t1.clear", 1, 0, 0, 0, 0, 0, 0, 1);
    step("t1.s0", 0, 1, 3, 4'b0001, 0, 0, 0, 1);
    req_data[3:0] = 4'd5;
    step("t1.s1", 0, 1, 5, 4'b0001, 0, 0, 0, 1);
    req_valid = '0;
    step("t1.drain", 0, 0, 0, 0, 0, 0, 0, 1);
    step("t1.out", 0, 0, 0, 0, 1, 8, 0, 1);

    // 3: req 1 (data 1) and req 3 (data 2) held valid; grants alternate 1,3,1,3
    req_valid = 4'b1010; req_data[7:4] = 4'd1; req_data[15:12] = 4'd2;
    step("t3.idle0", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      automatic int id = (b % 2 == 0) ? 1 : 3;
      automatic int d  = (b % 2 == 0) ? 1 : 2;
      step("t3.clear", 1, 0, 0, 0, 0, 0, 0, 1);
      step("t3.s0", 0, 1, d, 32'(1) << id, 0, 0, 0, 1);
      step("t3.s1", 0, 1, d, 32'(1) << id, 0, 0, 0, 1);
      step("t3.drain", 0, 0, 0, 0, 0, 0, 0, 1);
      if (b == 3) req_valid = '0;
      step("t3.out", 0, 0, 0, 0, 1, 2 * d, id, 1);
      step("t3.idle", 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // 2: req 2 sends 15, 15 (now IDLE cycle already consumed above, drive for the next)
    req_valid = 4'b0100; req_data[11:8] = 4'd15;
    step("t2.idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t2.clear", 1, 0, 0, 0, 0, 0, 0, 1);
    step("t2.s0", 0, 1, 15, 4'b0100, 0, 0, 0, 1);
    step("t2.s1", 0, 1, 15, 4'b0100, 0, 0, 0, 1);
    req_valid = '0;
    step("t2.drain", 0, 0, 0, 0, 0, 0, 0, 1);
    step("t2.out", 0, 0, 0, 0, 1, 30, 2, 1);

    // 4: res_ready low for 4 OUT cycles, other requests pending meanwhile
    req_valid = 4'b0001; req_data[3:0] = 4'd6; res_ready = 1'b0;
    step("t4.idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t4.clear", 1, 0, 0, 0, 0, 0, 0, 1);
    step("t4.s0", 0, 1, 6, 4'b0001, 0, 0, 0, 1);
    step("t4.s1", 0, 1, 6, 4'b0001, 0, 0, 0, 1);
    req_valid = 4'b0011;
    step("t4.drain", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("t4.hold", 0, 0, 0, 0, 1, 12, 0, 1);
    res_ready = 1'b1;
    step("t4.hs", 0, 0, 0, 0, 1, 12, 0, 1);
    req_valid = '0;
    step("t4.idle_after", 0, 0, 0, 0, 0, 0, 0, 0);

    // 5: req 0 sends 7, stalls 3 cycles, then 4
    req_valid = 4'b0001; req_data[3:0] = 4'd7;
    step("t5.idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t5.clear", 1, 0, 0, 0, 0, 0, 0, 1);
    step("t5.s0", 0, 1, 7, 4'b0001, 0, 0, 0, 1);
    req_valid = '0;
    for (int i = 0; i < 3; i++) step("t5.gap", 0, 0, 0, 4'b0001, 0, 0, 0, 1);
    req_valid = 4'b0001; req_data[3:0] = 4'd4;
    step("t5.s1", 0, 1, 4, 4'b0001, 0, 0, 0, 1);
    req_valid = '0;
    step("t5.drain", 0, 0, 0, 0, 0, 0, 0, 1);
    step("t5.out", 0, 0, 0, 0, 1, 11, 0, 1);
    step("t5.idle_after", 0, 0, 0, 0, 0, 0, 0, 0);

    // 6: reset mid-STREAM after one sample, then a fresh burst must start clean
    req_valid = 4'b0001; req_data[3:0] = 4'd9;
    step("t6.idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t6.clear", 1, 0, 0, 0, 0, 0, 0, 1);
    step("t6.s0", 0, 1, 9, 4'b0001, 0, 0, 0, 1);
    rst = 1'b0; req_data[3:0] = 4'd1;
    step("t6.rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6.rst.res_data", 32'(res_data), 0);
    rst = 1'b1;
    step("t6.idle2", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t6.clear2", 1, 0, 0, 0, 0, 0, 0, 1);
    step("t6.s0b", 0, 1, 1, 4'b0001, 0, 0, 0, 1);
    step("t6.s1b", 0, 1, 1, 4'b0001, 0, 0, 0, 1);
    req_valid = '0;
    step("t6.drain", 0, 0, 0, 0, 0, 0, 0, 1);
    step("t6.out", 0, 0, 0, 0, 1, 2, 0, 1);
    step("t6.idle_after", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/summer_arbiter.md
Name: summer_arbiter

Overview:
- Shares one tree_summer-style accumulator among NUM_REQ requesters.
- Grants the accumulator round-robin for one complete burst of NUM_SAMPLES samples.
- Clears the accumulator, streams the granted requester's samples into it, then captures the sum.
- Returns the sum, tagged with the requester id, over a valid/ready result port.

Parameters:
NUM_REQ, 4, number of requesters sharing the accumulator
NUM_SAMPLES, 2, samples per burst (>=2)
DATA_SIZE, 4, unsigned sample width
Derived: SUM_W = $clog2(NUM_SAMPLES)+DATA_SIZE; ID_W = max(1,$clog2(NUM_REQ))

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester sample valid
req_data  input  NUM_REQ*DATA_SIZE  per-requester sample; requester i in bits [i*DATA_SIZE +: DATA_SIZE]
req_ready  output  NUM_REQ  per-requester sample accept
acc_clr  output  1  synchronous clear of accumulator sum and count
acc_valid  output  1  accumulator add-enable
acc_data  output  DATA_SIZE  sample to accumulator
acc_sum  input  SUM_W  accumulator registered sum
res_valid  output  1  result valid
res_data  output  SUM_W  burst sum
res_id  output  ID_W  requester that owned the burst
res_ready  input  1  result consumer ready
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release):
  - state=IDLE; count=0; last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - All outputs 0: res_valid, res_data, res_id, req_ready, acc_valid, acc_clr, acc_data, busy.
- Reset mid-burst aborts the burst and discards partial data. The accumulator receives acc_clr before the next burst, so no stale sum leaks.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, OUT.
- IDLE:
  - If any req_valid is high, grant the first requester with req_valid high, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register grant; go to CLEAR.
  - Otherwise stay.
- CLEAR: acc_clr=1 for exactly one cycle; count<=0; go to STREAM.
- STREAM:
  - req_ready[grant]=1; all other req_ready=0.
  - A transfer occurs when req_valid[grant]&req_ready[grant].
  - On a transfer: acc_valid=1, acc_data=req_data slice of grant, count++.
  - If req_valid[grant] is low: acc_valid=0, count held (stall; no timeout).
  - Transfer with count==NUM_SAMPLES-1 -> go to DRAIN.
- DRAIN: one cycle, no acc_valid. acc_sum now holds the final sum; res_data<=acc_sum, res_id<=grant. Go to OUT.
- OUT:
  - res_valid=1; res_data and res_id held stable.
  - On res_valid&res_ready: last_grant<=grant, res_valid falls next cycle, go to IDLE.
- Grant is locked for the whole burst. Requests from other requesters are ignored until the FSM returns to IDLE.
- Simultaneous events:
  - Requests arriving during OUT wait for IDLE.
  - A new arbitration takes one IDLE cycle after the handshake. No back-to-back OUT->CLEAR path.
- Latency: first req_valid sampled in IDLE at cycle 0 -> res_valid at cycle NUM_SAMPLES+3 with no stalls.
- Throughput: one burst per NUM_SAMPLES+4 cycles when res_ready is held high.
- Arithmetic:
  - Unsigned. SUM_W is sufficient for NUM_SAMPLES*(2^DATA_SIZE-1), so there is no overflow.
  - acc_data is zero-extended by the accumulator.
- Outputs acc_valid, acc_data and req_ready are combinational from state, grant and req_valid. acc_data=0 when acc_valid=0.
- The accumulator instance must honour acc_clr: zero its sum and count on the clk edge where acc_clr=1.

Test Plan:
Defaults NUM_REQ=4, NUM_SAMPLES=2, DATA_SIZE=4, bench accumulator model with clear. res_ready high unless stated.
1. After reset, req 0 sends 3 then 5 back-to-back -> acc_clr pulses at cycle 1, acc_valid at cycles 2-3, res_valid at cycle 5 with res_data=8, res_id=0.
2. Req 2 sends 15 then 15 -> res_data=30 (5-bit, no overflow), res_id=2.
3. Req 1 and req 3 hold req_valid continuously, data 1 and 2 -> results alternate id 1 (sum 2), id 3 (sum 4), id 1, id 3; req_ready never high for the non-granted requester.
4. res_ready low 4 cycles during OUT -> res_valid, res_data and res_id stable throughout; no req_ready asserted; handshake on cycle 5 returns to IDLE next cycle.
5. Req 0 sends 7, drops req_valid for 3 cycles, then sends 4 -> acc_valid low during the gap, count held, res_data=11, res_valid at cycle 8.
6. rst asserted low mid-STREAM after one sample (9) -> all outputs 0 immediately. After release, req 0 sends 1,1 -> acc_clr precedes the data and res_data=2, res_id=0.
